read_return_buffer: RTL and testbench

- Downstream neighbour of the backend controller; sits on the returned-data channel between the backend controller and the frontend controller.
- Captures every read beat the backend produces and holds it in an in-order FIFO. Delivers beats to the frontend with a valid/ready handshake.
- Drives the backend stall input, which freezes the backend issue FIFO, so that no beat is lost when the frontend back-pressures.

---
 rtl/read_return_buffer_pkg.sv | 9 +
 rtl/rd_return_fifo_core.sv | 41 ++++
 rtl/read_return_buffer.sv | 50 +++++
 tb/tb_read_return_buffer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/read_return_buffer_pkg.sv
// read_return_buffer_pkg: shared backend constants and the read-beat type.
`ifndef DQ_BITS
`define DQ_BITS 8
`endif
package read_return_buffer_pkg;
  localparam int RD_RET_DEPTH = 8;
  localparam int RD_RET_STALL_MARGIN = 3;
  typedef logic [`DQ_BITS*8-1:0] rd_beat_t;
endpackage

// File: rtl/rd_return_fifo_core.sv
// rd_return_fifo_core: in-order storage, wrapping pointers and occupancy counter.
module rd_return_fifo_core
  import read_return_buffer_pkg::*;
#(
  parameter int DATA_W = $bits(rd_beat_t),
  parameter int DEPTH = RD_RET_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              power_on_rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [OW-1:0]     occupancy,
  output logic [OW-1:0]     occupancy_next,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign occupancy_next = (push && !pop) ? occupancy + 1'b1 :
                          (pop && !push) ? occupancy - 1'b1 : occupancy;
  assign full = occupancy == OW'(DEPTH);
  assign empty = occupancy == '0;
  assign rdata = mem[rd_ptr];
  // Full and empty come from the counter; pointers just wrap.
  always_ff @(posedge clk or negedge power_on_rst_n)
    if (!power_on_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occupancy <= occupancy_next;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/read_return_buffer.sv
// read_return_buffer: buffers backend read beats for the frontend, stalling the
// backend early enough that beats already in flight still find room.
module read_return_buffer
  import read_return_buffer_pkg::*;
#(
  parameter int DATA_W = `DQ_BITS*8,
  parameter int DEPTH = RD_RET_DEPTH,
  parameter int STALL_MARGIN = RD_RET_STALL_MARGIN,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              power_on_rst_n,
  input  logic [DATA_W-1:0] i_backend_read_data,
  input  logic              i_backend_read_data_valid,
  output logic              o_backend_controller_stall,
  output logic [DATA_W-1:0] o_frontend_read_data,
  input  logic              i_frontend_controller_ready,
  output logic              o_frontend_read_data_valid,
  output logic [OW-1:0]     o_occupancy,
  output logic              o_overflow
);
  localparam logic [OW-1:0] STALL_TH = OW'(DEPTH - STALL_MARGIN);
  logic [OW-1:0] occupancy_next;
  logic [DATA_W-1:0] head;
  logic full, empty, push, pop;
  assign pop = !empty && i_frontend_controller_ready;
  assign push = i_backend_read_data_valid && (!full || pop);
  assign o_frontend_read_data_valid = !empty;
  assign o_frontend_read_data = empty ? '0 : head;
  rd_return_fifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_core (
    .clk(clk),
    .power_on_rst_n(power_on_rst_n),
    .push(push),
    .pop(pop),
    .wdata(i_backend_read_data),
    .rdata(head),
    .occupancy(o_occupancy),
    .occupancy_next(occupancy_next),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge power_on_rst_n)
    if (!power_on_rst_n) begin
      o_backend_controller_stall <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_backend_controller_stall <= occupancy_next >= STALL_TH;
      if (i_backend_read_data_valid && full && !pop) o_overflow <= 1'b1;
    end
endmodule

// File: tb/tb_read_return_buffer.sv
// tb_read_return_buffer: vector table plus queue scoreboard for read_return_buffer.
module tb_read_return_buffer;
  import read_return_buffer_pkg::*;
  localparam int DEPTH = RD_RET_DEPTH;
  localparam int TH = RD_RET_DEPTH - RD_RET_STALL_MARGIN;
  logic clk = 1'b0;
  logic power_on_rst_n = 1'b0;
  rd_beat_t in_data = '0;
  logic in_valid = 1'b0;
  logic ready = 1'b0;
  logic stall, out_valid, overflow;
  rd_beat_t out_data;
  logic [3:0] occ;
  int checks = 0;
  int errors = 0;
  rd_beat_t q[$];
  logic m_ovf = 1'b0;
  typedef struct {
    logic v;
    rd_beat_t d;
    logic r;
    int occ;
    logic stall;
    logic valid;
    rd_beat_t head;
  } vec_t;
  vec_t vecs[12];
  always #5 clk = ~clk;
  read_return_buffer dut (
    .clk(clk),
    .power_on_rst_n(power_on_rst_n),
    .i_backend_read_data(in_data),
    .i_backend_read_data_valid(in_valid),
    .o_backend_controller_stall(stall),
    .o_frontend_read_data(out_data),
    .i_frontend_controller_ready(ready),
    .o_frontend_read_data_valid(out_valid),
    .o_occupancy(occ),
    .o_overflow(overflow)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  // One clock: drive inputs, update the model, then compare 1 time unit after the edge.
  task automatic step(input logic v, input rd_beat_t d, input logic r);
    int sz;
    logic p;
    in_valid = v;
    in_data = v ? d : 'x;
    ready = r;
    sz = q.size();
    p = (sz != 0) && r;
    if (p) chk("pop_data", out_data, q.pop_front());
    if (v) begin
      if (sz < DEPTH || p) q.push_back(d);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("occupancy", occ, q.size());
    chk("valid", out_valid, q.size() != 0);
    chk("stall", stall, q.size() >= TH);
    chk("overflow", overflow, m_ovf);
    chk("head", out_data, q.size() != 0 ? q[0] : '0);
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    ready = 1'b0;
    power_on_rst_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 power_on_rst_n = 1'b1;
  endtask
  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) step(1'b0, '0, 1'b1);
    chk("drained", q.size(), 0);
  endtask
  initial begin
    rd_beat_t held;
    int pushed, cyc;
    vecs[0] = '{1'b1, 64'hA5A5_0001, 1'b1, 1, 1'b0, 1'b1, 64'hA5A5_0001};
    vecs[1] = '{1'b0, 64'h0, 1'b1, 0, 1'b0, 1'b0, 64'h0};
    for (int i = 0; i < 5; i++)
      vecs[2+i] = '{1'b1, rd_beat_t'(i + 1), 1'b0, i + 1, i + 1 >= 5, 1'b1, 64'h1};
    for (int i = 0; i < 5; i++)
      vecs[7+i] = '{1'b0, 64'h0, 1'b1, 4 - i, 1'b0, i != 4, i != 4 ? rd_beat_t'(i + 2) : '0};
    do_reset();
    chk("rst_occ", occ, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r);
      chk($sformatf("vec%0d_occ", i), occ, vecs[i].occ);
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].stall);
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].valid);
      chk($sformatf("vec%0d_head", i), out_data, vecs[i].head);
    end
    for (int i = 0; i < 5; i++) step(1'b1, rd_beat_t'(64'h100 + i), 1'b0);
    chk("margin_stall", stall, 1);
    for (int i = 5; i < 8; i++) step(1'b1, rd_beat_t'(64'h100 + i), 1'b0);
    chk("margin_occ8", occ, 8);
    chk("margin_no_ovf", overflow, 0);
    step(1'b1, 64'hDEAD, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", out_data, 64'h100);
    chk("ovf_occ", occ, 8);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    chk("ovf_sticky", overflow, 1);
    for (int i = 0; i < 20; i++) step(1'b1, rd_beat_t'(64'h200 + i), 1'b1);
    chk("pass_occ", occ, 8);
    drain();
    step(1'b1, 64'hCAFE_F00D, 1'b0);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b0);
      chk("hold_data", out_data, held);
    end
    drain();
    for (int i = 0; i < 6; i++) step(1'b1, rd_beat_t'(64'h300 + i), 1'b0);
    chk("pre_rst_occ", occ, 6);
    in_valid = 1'b0;
    #2 power_on_rst_n = 1'b0;
    #2;
    chk("async_valid", out_valid, 0);
    chk("async_stall", stall, 0);
    chk("async_occ", occ, 0);
    chk("async_ovf", overflow, 0);
    do_reset();
    step(1'b1, 64'hBEEF, 1'b0);
    chk("post_rst_head", out_data, 64'hBEEF);
    drain();
    pushed = 0;
    cyc = 0;
    while (pushed < 1000 && cyc < 20000) begin
      logic v;
      v = !stall && ($urandom_range(9) < 7);
      step(v, {$urandom, $urandom}, $urandom_range(1));
      if (v) pushed++;
      cyc++;
    end
    chk("random_pushed", pushed, 1000);
    drain();
    chk("random_no_drop", overflow, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
